// File: rtl/vnu_ext_accum.sv
// -----------------------------------------------------------------------------
// vnu_ext_accum
//
// Serial variable-node accumulator for the shuffled GLDPC VNU. One column is
// processed at a time: DEG check-to-variable messages are loaded one per beat
// (the channel LLR rides along with the first beat) while the a-posteriori sum
// is accumulated. The block then emits DEG extrinsic messages, one per beat,
// each equal to the sum minus that beat's own message. Results are saturated
// symmetrically to [-1023, +1023].
//
// The output feeds an 11-bit two's-complement to sign-magnitude converter,
// which has no code for -1024. For that reason the saturation clamps to
// -1023 instead of -1024.
//
// Ports
//   i_clk    : clock, rising edge.
//   i_rst_n  : asynchronous active-low reset.
//   i_llr    : channel LLR, sampled on the first accepted beat of a column.
//   i_msg    : check-to-variable message, one per accepted beat.
//   i_valid  : i_msg (and i_llr on beat 0) valid.
//   o_ready  : block accepts a message this cycle (LOAD phase only).
//   o_data   : extrinsic message for index o_idx.
//   o_idx    : message index 0..DEG-1 that o_data belongs to.
//   o_last   : high on the beat with index DEG-1.
//   o_app    : saturated a-posteriori sum, constant over a column.
//   o_hard   : sign of the unsaturated a-posteriori sum (1 = negative).
//   o_valid  : emit-side outputs valid.
//   i_ready  : downstream accepts the current output beat.
//
// DEG must lie in 2..15. ACC_W is sized so that the LLR plus DEG messages
// cannot overflow the accumulator.
// -----------------------------------------------------------------------------
module vnu_ext_accum #(
    parameter int DEG   = 4,
    parameter int ACC_W = 11 + $clog2(DEG + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:0] i_llr,
    input  logic [10:0] i_msg,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_data,
    output logic [3:0]  o_idx,
    output logic        o_last,
    output logic [10:0] o_app,
    output logic        o_hard,
    output logic        o_valid,
    input  logic        i_ready
);

    localparam int IDX_W = (DEG > 1) ? $clog2(DEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);
    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(1023);
    localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Sign-extend an 11-bit two's-complement value to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext11(input logic [10:0] v);
        sext11 = {{(ACC_W - 11){v[10]}}, v};
    endfunction

    // Symmetric saturation to 11 bits; -1024 (0x400) is never produced.
    function automatic logic [10:0] sat11(input logic signed [ACC_W-1:0] x);
        logic [10:0] r;
        if (x > POS_LIM) begin
            r = 11'h3FF;
        end else if (x < NEG_LIM) begin
            r = 11'h401;
        end else begin
            r = x[10:0];
        end
        sat11 = r;
    endfunction

    // Registered state
    state_t                   state_r;
    logic [IDX_W-1:0]         cnt_r;
    logic [IDX_W-1:0]         idx_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [10:0]              buf_r [0:DEG-1];
    logic                     o_ready_r;
    logic                     o_valid_r;
    logic [10:0]              o_data_r;
    logic                     o_last_r;
    logic [10:0]              o_app_r;
    logic                     o_hard_r;

    // Next-state values
    state_t                   state_s;
    logic [IDX_W-1:0]         cnt_s;
    logic [IDX_W-1:0]         idx_s;
    logic [IDX_W-1:0]         nidx_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic                     buf_we_s;
    logic                     ready_s;
    logic                     valid_s;
    logic [10:0]              data_s;
    logic                     last_s;
    logic [10:0]              app_s;
    logic                     hard_s;

    // Next-state and next-output logic for the LOAD/EMIT controller.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        nidx_s   = idx_r;
        acc_s    = acc_r;
        sum_s    = acc_r;
        buf_we_s = 1'b0;
        ready_s  = o_ready_r;
        valid_s  = o_valid_r;
        data_s   = o_data_r;
        last_s   = o_last_r;
        app_s    = o_app_r;
        hard_s   = o_hard_r;

        case (state_r)
            ST_LOAD: begin
                // o_ready comes up one edge after reset release and stays up
                // until the final message of the column is taken.
                ready_s = 1'b1;
                if (i_valid && o_ready_r) begin
                    buf_we_s = 1'b1;
                    if (cnt_r == '0) begin
                        sum_s = sext11(i_llr) + sext11(i_msg);
                    end else begin
                        sum_s = acc_r + sext11(i_msg);
                    end
                    acc_s = sum_s;
                    if (cnt_r == LAST_IDX) begin
                        // Column complete: present extrinsic beat 0 right away.
                        // buffer[0] was written on an earlier beat (DEG >= 2).
                        cnt_s   = '0;
                        ready_s = 1'b0;
                        state_s = ST_EMIT;
                        valid_s = 1'b1;
                        idx_s   = '0;
                        last_s  = 1'b0;
                        data_s  = sat11(sum_s - sext11(buf_r[0]));
                        app_s   = sat11(sum_s);
                        hard_s  = sum_s[ACC_W-1];
                    end else begin
                        cnt_s = cnt_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_EMIT: begin
                ready_s = 1'b0;
                if (o_valid_r && i_ready) begin
                    if (idx_r == LAST_IDX) begin
                        // Loop back: o_ready rises as o_valid falls.
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        ready_s = 1'b1;
                        state_s = ST_LOAD;
                    end else begin
                        nidx_s = idx_r + IDX_W'(1);
                        idx_s  = nidx_s;
                        data_s = sat11(acc_r - sext11(buf_r[nidx_s]));
                        last_s = (nidx_s == LAST_IDX);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = ST_LOAD;
                ready_s = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // Controller state, accumulator and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_LOAD;
            cnt_r     <= '0;
            idx_r     <= '0;
            acc_r     <= '0;
            o_ready_r <= 1'b0;
            o_valid_r <= 1'b0;
            o_data_r  <= 11'h000;
            o_last_r  <= 1'b0;
            o_app_r   <= 11'h000;
            o_hard_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            acc_r     <= acc_s;
            o_ready_r <= ready_s;
            o_valid_r <= valid_s;
            o_data_r  <= data_s;
            o_last_r  <= last_s;
            o_app_r   <= app_s;
            o_hard_r  <= hard_s;
        end
    end

    // Message buffer: one entry per column position, written during LOAD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEG; i++) begin
                buf_r[i] <= 11'h000;
            end
        end else if (buf_we_s) begin
            buf_r[cnt_r] <= i_msg;
        end
    end

    assign o_ready = o_ready_r;
    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_idx   = 4'(idx_r);
    assign o_last  = o_last_r;
    assign o_app   = o_app_r;
    assign o_hard  = o_hard_r;

endmodule

// File: tb/tb_vnu_ext_accum.sv
// -----------------------------------------------------------------------------
// tb_vnu_ext_accum
//
// Directed bench for vnu_ext_accum (DEG=4). Each loaded column pushes its
// expected extrinsic beats (computed with plain integer arithmetic from the
// LLR and messages) onto a queue; a negedge compare process checks every
// valid output beat against the queue head and pops it when downstream
// accepts. Directed steps add literal expectations for key values.
// -----------------------------------------------------------------------------
module tb_vnu_ext_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] i_llr;
    logic [10:0] i_msg;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready;
    logic [10:0] o_data;
    logic [3:0]  o_idx;
    logic        o_last;
    logic [10:0] o_app;
    logic        o_hard;
    logic        o_valid;

    always #5 clk = ~clk;

    vnu_ext_accum #(.DEG(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_llr   (i_llr),
        .i_msg   (i_msg),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .o_app   (o_app),
        .o_hard  (o_hard),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    int errs   = 0;
    int checks = 0;
    bit running = 1'b0;

    typedef struct {
        int data;
        int idx;
        bit last;
        int app;
        bit hard;
    } beat_t;

    beat_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 1023) return 1023;
        else if (x < -1023) return -1023;
        else return x;
    endfunction

    // Reference: extrinsic = saturate(llr + sum of other messages).
    task automatic push_col(input int llr, input int m [4]);
        int    sum;
        beat_t b;
        sum = llr;
        for (int k = 0; k < 4; k++) sum += m[k];
        for (int k = 0; k < 4; k++) begin
            b.data = sat(sum - m[k]);
            b.idx  = k;
            b.last = (k == 3);
            b.app  = sat(sum);
            b.hard = (sum < 0);
            exp_q.push_back(b);
        end
    endtask

    function automatic int sdata();
        return int'($signed(o_data));
    endfunction

    function automatic int sapp();
        return int'($signed(o_app));
    endfunction

    // Every cycle after reset: check handshake invariant and output beats.
    always @(negedge clk) begin : cmp
        beat_t e;
        if (running) begin
            chk("ready_is_not_valid", int'(o_ready), int'(!o_valid));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_beat: got idx %0d data %0d expected no beat", o_idx, sdata());
                end else begin
                    e = exp_q[0];
                    chk("beat_data", sdata(), e.data);
                    chk("beat_idx", int'(o_idx), e.idx);
                    chk("beat_last", int'(o_last), int'(e.last));
                    chk("beat_app", sapp(), e.app);
                    chk("beat_hard", int'(o_hard), int'(e.hard));
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 0);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_data"},  int'(o_data), 0);
        chk({tag, "_idx"},   int'(o_idx), 0);
        chk({tag, "_last"},  int'(o_last), 0);
        chk({tag, "_app"},   int'(o_app), 0);
        chk({tag, "_hard"},  int'(o_hard), 0);
    endtask

    // Load one column back-to-back; returns at posedge+1 after the last accept.
    task automatic load_col(input int llr, input int m0, input int m1, input int m2, input int m3);
        int m [4];
        m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
        push_col(llr, m);
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_msg   = 11'(m[k]);
            i_llr   = (k == 0) ? 11'(llr) : 11'h2B5;
            chk("load_ready", int'(o_ready), 1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
    endtask

    // Wait (bounded) until the block is back in LOAD with nothing pending.
    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!o_valid && o_ready) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_idle"}, int'(done), 1);
        chk({tag, "_all_beats"}, exp_q.size(), 0);
    endtask

    initial begin
        int gv [7];
        int gm [4];
        int mi;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_llr   = 11'h000;
        i_msg   = 11'h000;
        i_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        running = 1'b1;
        chk("release_ready", int'(o_ready), 1);

        // Nominal: sum 20 -> 15,23,13,19
        load_col(10, 5, -3, 7, 1);
        chk("nom_latency_valid", int'(o_valid), 1);
        chk("nom_d0", sdata(), 15);
        chk("nom_app", sapp(), 20);
        chk("nom_hard", int'(o_hard), 0);
        @(posedge clk); #1;
        chk("nom_d1", sdata(), 23);
        wait_idle("nom");

        // Positive saturation
        load_col(1000, 500, 500, 500, 500);
        chk("satp_d0_raw", int'(o_data), 'h3FF);
        chk("satp_app", sapp(), 1023);
        wait_idle("satp");

        // Negative saturation, never 0x400
        load_col(-1024, -1000, -1000, -1000, -1000);
        chk("satn_d0_raw", int'(o_data), 'h401);
        chk("satn_app", sapp(), -1023);
        chk("satn_hard", int'(o_hard), 1);
        wait_idle("satn");

        // Backpressure on beat 1 for three cycles: sum 10 -> 9,8,7,6
        load_col(0, 1, 2, 3, 4);
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_idx_hold", int'(o_idx), 1);
            chk("bp_data_hold", sdata(), 8);
            chk("bp_ready_low", int'(o_ready), 0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        chk("bp_idx_after", int'(o_idx), 1);
        @(posedge clk); #1;
        chk("bp_idx_next", int'(o_idx), 2);
        wait_idle("bp");

        // Input gaps: valid 1,0,0,1,0,1,1 with msgs 2,4,6,8, llr 0
        gv = '{1, 0, 0, 1, 0, 1, 1};
        gm = '{2, 4, 6, 8};
        push_col(0, gm);
        mi = 0;
        for (int c = 0; c < 7; c++) begin
            i_valid = gv[c][0];
            i_msg   = (gv[c] != 0) ? 11'(gm[mi]) : 11'h2AA;
            i_llr   = (gv[c] != 0 && mi == 0) ? 11'h000 : 11'h123;
            if (gv[c] != 0) chk("gap_ready", int'(o_ready), 1);
            else chk("gap_no_emit", int'(o_valid), 0);
            @(posedge clk); #1;
            if (gv[c] != 0) mi++;
        end
        i_valid = 1'b0;
        chk("gap_valid", int'(o_valid), 1);
        chk("gap_d0", sdata(), 18);
        chk("gap_app", sapp(), 20);
        // Extra i_valid pulses while emitting must be ignored
        i_valid = 1'b1;
        i_msg   = 11'd100;
        i_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("gap_extra_ignored", sdata(), 18);
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_idle("gap");

        // Zero-sum boundary
        load_col(3, -3, 0, 0, 0);
        chk("zero_app", sapp(), 0);
        chk("zero_hard", int'(o_hard), 0);
        chk("zero_d0", sdata(), 3);
        wait_idle("zero");

        // Mid-EMIT reset during beat 2
        load_col(10, 5, -3, 7, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst_at_beat2", int'(o_idx), 2);
        rst_n   = 1'b0;
        running = 1'b0;
        #1;
        chk_all_zero("mrst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mrst_no_stale_beat", int'(o_valid), 0);
        end
        running = 1'b1;
        chk("mrst_ready", int'(o_ready), 1);
        load_col(-1, 0, 0, 0, 0);
        chk("mrst_d0", sdata(), -1);
        chk("mrst_app", sapp(), -1);
        chk("mrst_hard", int'(o_hard), 1);
        wait_idle("mrst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vnu_ext_accum.md
# vnu_ext_accum

Serial variable-node accumulator for the shuffled GLDPC VNU. It accepts one column's channel LLR and DEG check-to-variable messages, all in two's complement, one message per beat. It forms the a-posteriori sum and then emits DEG extrinsic messages (sum minus own message), saturated symmetrically to 11 bits. The output feeds directly into the 11-bit two's-complement-to-sign-magnitude converter ahead of the check-node side.

## Interface
- DEG, 4: column degree, i.e. messages per column; legal range 2..15.
- ACC_W, 11+$clog2(DEG+1): internal accumulator width; never overflows.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_llr  in  11  channel LLR, two's complement; sampled on the first accepted message beat of a column.
- i_msg  in  11  check-to-variable message, two's complement.
- i_valid  in  1  i_msg (and i_llr on beat 0) valid.
- o_ready  out  1  block accepts a message this cycle.
- o_data  out  11  extrinsic message, two's complement, range [-1023, +1023].
- o_idx  out  4  index 0..DEG-1 of the message o_data belongs to.
- o_last  out  1  high with beat DEG-1.
- o_app  out  11  saturated a-posteriori sum; constant for all beats of a column.
- o_hard  out  1  hard decision: sign of the unsaturated sum (1 = negative).
- o_valid  out  1  o_data, o_idx, o_last, o_app and o_hard are valid.
- i_ready  in  1  downstream accepts the output beat.

## Operation
- States: LOAD and EMIT.
- LOAD: o_ready=1.
  - Each i_valid&o_ready beat stores i_msg into buffer[cnt] and adds it to acc.
  - On cnt==0, acc loads sign-extended i_llr + i_msg.
  - After beat DEG-1 is accepted: cnt returns to 0, o_ready drops, and the state moves to EMIT.
- EMIT: o_ready=0.
  - Beat k presents o_data = sat(acc - buffer[k]).
  - A beat advances only on o_valid&i_ready.
  - After beat DEG-1 is accepted, the state returns to LOAD.
- sat(x): +1023 if x>1023; -1023 if x<-1023; else x[10:0].
  - -1024 is never produced, because the downstream sign-magnitude converter cannot represent it.
- o_app = sat(acc). o_hard = acc[ACC_W-1].
- Single buffer: no overlap between EMIT of column n and LOAD of column n+1.
- Extra i_valid pulses while o_ready=0 are ignored; there is no storage for them.

## Timing
- Reset values: o_ready=0, o_valid=0, o_data=0, o_idx=0, o_last=0, o_app=0, o_hard=0; state LOAD; cnt=0; acc=0.
- Reset release: o_ready rises on the first rising edge after i_rst_n deasserts.
- All outputs are registered.
- Latency: o_valid rises one cycle after the edge that accepts message DEG-1; o_data for index 0 is present in that same cycle.
- Backpressure: while o_valid&!i_ready, every output holds stable.
- Loop-back: o_ready rises the cycle after the edge accepting beat DEG-1 of EMIT; o_valid falls in that same cycle.
- Best-case throughput: 2·DEG cycles per column.
- Reset mid-operation:
  - Asynchronous clear of all state and outputs in any state.
  - The partial column is discarded.
  - No output beat is emitted for it after release.
- Input gaps (i_valid low) stall LOAD without changing cnt or acc.

## Test plan
- **Nominal** (DEG=4): llr=10, msgs 5,-3,7,1 back-to-back, i_ready=1 -> o_data 15,23,13,19; o_idx 0..3; o_last on beat 3; o_app=20; o_hard=0; o_valid rises 1 cycle after 4th accept.
- **Saturation**:
  - llr=1000, msgs 500×4 -> o_data 1023×4 (0x3FF), o_app=1023.
  - llr=-1024, msgs -1000×4 -> o_data -1023×4 (0x401, never 0x400), o_app=-1023, o_hard=1.
- **Backpressure**: i_ready low 3 cycles on beat 1 -> o_data and o_idx=1 held for 3 cycles, no beat skipped, o_ready stays 0 until beat 3 accepted.
- **Input gaps**: i_valid 1,0,0,1,0,1,1 with msgs 2,4,6,8 and llr=0 -> exactly 4 accepts; sum=20; o_data 18,16,14,12; extra i_valid during EMIT ignored.
- **Mid-EMIT reset**: i_rst_n low during beat 2 -> all outputs 0 immediately. After release, a new column (llr=-1, msgs 0×4) yields o_data -1×4, o_hard=1, o_app=-1.
- **Zero-sum boundary**: llr=3, msgs -3,0,0,0 -> o_app=0, o_hard=0, o_data 3,0,0,0.
